// File: rtl/cr_branch_eval.sv
// Condition Register reader: evaluates bc/bclr/bcctr branch conditions
// against the committed CR, owns the Count Register and reports
// taken/illegal over a valid/ready result handshake. A request that arrives
// while an older CR write is still pending waits until the CR settles.
module cr_branch_eval #(
    parameter int CR_WIDTH  = 32,
    parameter int CR_DEPTH  = 5,
    parameter int CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4:0]           req_bo,
    input  logic [CR_DEPTH-1:0]  req_bi,
    input  logic [1:0]           req_kind,
    input  logic [CR_WIDTH-1:0]  cr_rd,
    input  logic                 cr_wr_pend,
    input  logic                 ctr_we,
    input  logic [CTR_WIDTH-1:0] ctr_wd,
    output logic [CTR_WIDTH-1:0] ctr_rd,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_taken,
    output logic                 res_illegal
);

    // BO uses big-endian numbering (BO[0] is the MSB), so architectural
    // BO[n] lives at vector bit 4-n.
    localparam int BO_COND_IGN = 4;   // BO[0]: ignore CR condition
    localparam int BO_COND_VAL = 3;   // BO[1]: required CR bit value
    localparam int BO_CTR_IGN  = 2;   // BO[2]: do not decrement / test CTR
    localparam int BO_CTR_ZERO = 1;   // BO[3]: branch when CTR reaches zero

    localparam logic [1:0] KIND_BCCTR = 2'b10;
    localparam logic [1:0] KIND_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CR = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  capture, eval_go;

    logic [4:0]            bo_p0;
    logic [CR_DEPTH-1:0]   bi_p0;
    logic [1:0]            kind_p0;

    logic [4:0]            ev_bo;
    logic [CR_DEPTH-1:0]   ev_bi;
    logic [1:0]            ev_kind;
    logic [CTR_WIDTH-1:0]  ctr_pre, ctr_new;
    logic                  legal, dec, ctr_ok, cond_ok;

    logic [CTR_WIDTH-1:0]  ctr;
    logic                  taken_p1, illegal_p1;

    // CR bit BI counted from the MSB: shift it up into the top position.
    function automatic logic cr_select(input logic [CR_WIDTH-1:0] cr,
                                       input logic [CR_DEPTH-1:0] bi);
        logic [CR_WIDTH-1:0] sh;
        sh = cr << bi;
        return sh[CR_WIDTH-1];
    endfunction

    // State register; reset drops any captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus capture/evaluate strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        eval_go   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    capture   = 1'b1;
                    eval_go   = ~cr_wr_pend;
                    state_nxt = cr_wr_pend ? WAIT_CR : RESP;
                end
            end
            WAIT_CR: begin
                if (!cr_wr_pend) begin
                    eval_go   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold the request fields while waiting for the CR to settle.
    always_ff @(posedge clk) begin
        if (capture) begin
            bo_p0   <= req_bo;
            bi_p0   <= req_bi;
            kind_p0 <= req_kind;
        end
    end

    // Branch condition; in the accept cycle the live request fields are used.
    always_comb begin
        ev_bo   = capture ? req_bo   : bo_p0;
        ev_bi   = capture ? req_bi   : bi_p0;
        ev_kind = capture ? req_kind : kind_p0;
        // A same-cycle mtctr is older than the branch, so it feeds the decrement.
        ctr_pre = ctr_we ? ctr_wd : ctr;
        ctr_new = ctr_pre - CTR_WIDTH'(1);
        legal   = (ev_kind != KIND_RSVD) &&
                  !((ev_kind == KIND_BCCTR) && !ev_bo[BO_CTR_IGN]);
        dec     = ~ev_bo[BO_CTR_IGN] & legal;
        ctr_ok  = ev_bo[BO_CTR_IGN] | ((ctr_new != '0) ^ ev_bo[BO_CTR_ZERO]);
        cond_ok = ev_bo[BO_COND_IGN] |
                  (cr_select(cr_rd, ev_bi) == ev_bo[BO_COND_VAL]);
    end

    // ---- eval -> response boundary ----
    // Result registers, loaded once per branch and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_p1   <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (eval_go) begin
            taken_p1   <= legal & ctr_ok & cond_ok;
            illegal_p1 <= ~legal;
        end
    end

    // Count register: branch decrement wins, otherwise mtctr in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                ctr <= '0;
        else if (eval_go && dec) ctr <= ctr_new;
        else if (ctr_we)        ctr <= ctr_wd;
    end

    assign req_ready   = (state == IDLE);
    assign res_valid   = (state == RESP);
    assign res_taken   = taken_p1;
    assign res_illegal = illegal_p1;
    assign ctr_rd      = ctr;

endmodule

// File: tb/tb_cr_branch_eval.sv
// Bench for cr_branch_eval: the driver issues branch requests and pushes the
// model's expected result into a queue at the evaluation edge; a negedge
// monitor compares every presented result, the handshake and the CTR.
module tb_cr_branch_eval;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_bo = '0;
    logic [4:0]  req_bi = '0;
    logic [1:0]  req_kind = '0;
    logic [31:0] cr_rd = '0;
    logic        cr_wr_pend = 1'b0;
    logic        ctr_we = 1'b0;
    logic [31:0] ctr_wd = '0;
    logic [31:0] ctr_rd;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_taken;
    logic        res_illegal;

    typedef struct packed {logic taken; logic illegal;} exp_t;
    exp_t        q[$];
    exp_t        last_push;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_ctr = '0;
    bit          exp_ready = 1'b1;
    bit          exp_valid = 1'b0;
    bit          mon_en = 1'b0;
    bit          rnd_mode = 1'b0;

    cr_branch_eval #(.CR_WIDTH(32), .CR_DEPTH(5), .CTR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bo(req_bo), .req_bi(req_bi), .req_kind(req_kind),
        .cr_rd(cr_rd), .cr_wr_pend(cr_wr_pend),
        .ctr_we(ctr_we), .ctr_wd(ctr_wd), .ctr_rd(ctr_rd),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_taken(res_taken), .res_illegal(res_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch semantics straight from the architectural rules.
    function automatic void model_eval(input logic [4:0] bo, input logic [4:0] bi,
                                       input logic [1:0] kind, input logic [31:0] cr,
                                       input logic [31:0] pre, output bit taken,
                                       output bit illegal, output logic [31:0] nxt);
        bit b[5];
        bit legal, crbit, ctr_ok, cond_ok, dec;
        logic [31:0] m1;
        for (int i = 0; i < 5; i++) b[i] = bo[4-i];
        crbit   = cr[31 - int'(bi)];
        legal   = (kind != 2'b11) && !(kind == 2'b10 && !b[2]);
        m1      = pre - 32'd1;
        ctr_ok  = b[2] || ((m1 != 0) != b[3]);
        cond_ok = b[0] || (crbit == b[1]);
        taken   = legal && ctr_ok && cond_ok;
        illegal = !legal;
        dec     = legal && !b[2];
        nxt     = dec ? m1 : pre;
    endfunction

    // One clock: model the CTR (and the branch result on an eval edge).
    task automatic tick(input bit do_eval, input logic [4:0] bo, input logic [4:0] bi,
                        input logic [1:0] kind);
        bit t, il;
        logic [31:0] pre, nx;
        @(posedge clk);
        pre = ctr_we ? ctr_wd : model_ctr;
        if (do_eval) begin
            model_eval(bo, bi, kind, cr_rd, pre, t, il, nx);
            last_push = '{taken: t, illegal: il};
            q.push_back(last_push);
            model_ctr = nx;
        end else begin
            model_ctr = pre;
        end
        #1;
    endtask

    // Background inputs that must not disturb a branch in progress.
    task automatic bg();
        if (rnd_mode) begin
            cr_rd     = $urandom;
            ctr_we    = ($urandom_range(0, 3) == 0);
            ctr_wd    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : $urandom;
            res_ready = 1'($urandom);
        end else begin
            cr_rd  = '0;
            ctr_we = 1'b0;
        end
    endtask

    task automatic garbage_req();
        req_valid = rnd_mode ? 1'($urandom) : 1'b0;
        req_bo    = 5'($urandom);
        req_bi    = 5'($urandom);
        req_kind  = 2'($urandom);
    endtask

    task automatic mtctr(input logic [31:0] v);
        bg();
        req_valid = 1'b0; ctr_we = 1'b1; ctr_wd = v;
        exp_ready = 1'b1; exp_valid = 1'b0;
        tick(1'b0, 5'd0, 5'd0, 2'd0);
        ctr_we = 1'b0;
    endtask

    // One branch: accept, k cycles of pending CR write, then a response
    // held for 'stall' cycles of res_ready low.
    task automatic txn(input logic [4:0] bo, input logic [4:0] bi, input logic [1:0] kind,
                       input int k, input int stall, input logic [31:0] cr_eval,
                       input bit acc_we, input logic [31:0] acc_wd);
        bg();
        exp_ready = 1'b1; exp_valid = 1'b0;
        req_valid = 1'b1; req_bo = bo; req_bi = bi; req_kind = kind;
        cr_wr_pend = (k > 0);
        if (k == 0) cr_rd = cr_eval;
        if (acc_we) begin ctr_we = 1'b1; ctr_wd = acc_wd; end
        tick(k == 0, bo, bi, kind);
        for (int i = 1; i <= k; i++) begin
            bg(); garbage_req();
            exp_ready = 1'b0; exp_valid = 1'b0;
            cr_wr_pend = (i < k);
            if (i == k) cr_rd = cr_eval;
            tick(i == k, bo, bi, kind);
        end
        for (int j = 0; j <= stall; j++) begin
            bg(); garbage_req();
            exp_ready = 1'b0; exp_valid = 1'b1;
            cr_wr_pend = rnd_mode ? 1'($urandom) : 1'b0;
            res_ready = (j == stall);
            tick(1'b0, bo, bi, kind);
        end
        req_valid = 1'b0; res_ready = 1'b0; cr_wr_pend = 1'b0; ctr_we = 1'b0;
        exp_ready = 1'b1; exp_valid = 1'b0;
    endtask

    // Monitor: handshake, CTR and every presented result against the queue.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("res_valid", 64'(res_valid), 64'(exp_valid));
            chk("ctr_rd", 64'(ctr_rd), 64'(model_ctr));
            if (res_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL res_unexpected: got res_valid=1 expected no pending result at %0t", $time);
                end else begin
                    chk("res_taken", 64'(res_taken), 64'(q[0].taken));
                    chk("res_illegal", 64'(res_illegal), 64'(q[0].illegal));
                    if (res_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #3;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_ctr", 64'(ctr_rd), 64'd0);
        chk("rst_taken", 64'(res_taken), 64'd0);
        chk("rst_illegal", 64'(res_illegal), 64'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Directed scenarios.
        rnd_mode = 1'b0;
        mtctr(32'd3);
        txn(5'b10000, 5'd0, 2'b00, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("t1_model", 64'(last_push), 64'(2'b10));
        chk("t1_ctr", 64'(ctr_rd), 64'd2);

        txn(5'b01100, 5'd2, 2'b00, 0, 0, 32'h2000_0000, 1'b0, 32'h0);
        chk("t2a_model", 64'(last_push), 64'(2'b10));
        txn(5'b01100, 5'd3, 2'b00, 0, 1, 32'h2000_0000, 1'b0, 32'h0);
        chk("t2b_model", 64'(last_push), 64'(2'b00));
        chk("t2_ctr", 64'(ctr_rd), 64'd2);

        txn(5'b01100, 5'd0, 2'b00, 3, 0, 32'h8000_0000, 1'b0, 32'h0);
        chk("t3_model", 64'(last_push), 64'(2'b10));

        mtctr(32'd0);
        txn(5'b10010, 5'd0, 2'b01, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("t4a_model", 64'(last_push), 64'(2'b00));
        chk("t4a_ctr", 64'(ctr_rd), 64'hFFFF_FFFF);
        txn(5'b10000, 5'd0, 2'b00, 0, 0, 32'h0, 1'b1, 32'd5);
        chk("t4b_model", 64'(last_push), 64'(2'b10));
        chk("t4b_ctr", 64'(ctr_rd), 64'd4);

        txn(5'b10000, 5'd0, 2'b10, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("t5a_model", 64'(last_push), 64'(2'b01));
        chk("t5a_ctr", 64'(ctr_rd), 64'd4);
        txn(5'b10100, 5'd0, 2'b11, 1, 0, 32'h0, 1'b0, 32'h0);
        chk("t5b_model", 64'(last_push), 64'(2'b01));

        txn(5'b10100, 5'd0, 2'b10, 0, 4, 32'h0, 1'b0, 32'h0);
        chk("t6_model", 64'(last_push), 64'(2'b10));

        // Reset while parked in WAIT_CR.
        exp_ready = 1'b1; exp_valid = 1'b0;
        req_valid = 1'b1; req_bo = 5'b01100; req_bi = 5'd0; req_kind = 2'b00;
        cr_wr_pend = 1'b1; cr_rd = '0; ctr_we = 1'b0;
        tick(1'b0, 5'd0, 5'd0, 2'd0);
        req_valid = 1'b0; exp_ready = 1'b0;
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_res_valid", 64'(res_valid), 64'd0);
        chk("rst_mid_ctr", 64'(ctr_rd), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        #3 rst = 1'b0;
        cr_wr_pend = 1'b0;
        model_ctr = '0;
        q.delete();
        exp_ready = 1'b1; exp_valid = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk("rst_mid_ready_after", 64'(req_ready), 64'd1);

        // Randomized branches with mtctr traffic, CR churn and back-pressure.
        rnd_mode = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) mtctr(32'($urandom_range(0, 2)));
            txn(5'($urandom), 5'($urandom), 2'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom, 1'($urandom_range(0, 3) == 0), 32'($urandom_range(0, 3)));
        end
        rnd_mode = 1'b0;
        bg();
        for (int n = 0; n < 3; n++) tick(1'b0, 5'd0, 5'd0, 2'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
